// File: rtl/core0_pkg.sv
// core0_pkg: shared core0 types for the execute/write-back/stack path.
//   commit_kind_t  - commit kind produced by the decoder/ALU
//   stack_op_t     - write operation presented to the stack unit
//   commit_state_t - write-back sequencer state
//   kind_to_op()   - first stack write op for a commit kind
package core0_pkg;

  typedef enum logic [1:0] {
    KIND_REPLACE     = 2'd0,
    KIND_POP_REPLACE = 2'd1,
    KIND_PUSH        = 2'd2,
    KIND_DOUBLE      = 2'd3
  } commit_kind_t;

  typedef enum logic [1:0] {
    OP_REPLACE_TOP = 2'd0,
    OP_POP_REPLACE = 2'd1,
    OP_PUSH        = 2'd2,
    OP_RSVD        = 2'd3
  } stack_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WR_LO = 2'd1,
    ST_WR_HI = 2'd2
  } commit_state_t;

  // DOUBLE consumes both operands with its low word, then pushes the high word.
  function automatic stack_op_t kind_to_op(input commit_kind_t k);
    case (k)
      KIND_REPLACE:     kind_to_op = OP_REPLACE_TOP;
      KIND_POP_REPLACE: kind_to_op = OP_POP_REPLACE;
      KIND_PUSH:        kind_to_op = OP_PUSH;
      default:          kind_to_op = OP_POP_REPLACE;
    endcase
  endfunction

endpackage

// File: rtl/alu_result_commit.sv
// alu_result_commit: write-back end of the ALU datapath.
//   Accepts a result from execute (in_valid/in_ready), sequences one or two
//   stack writes (stack_valid/stack_ready) and owns the architectural carry
//   flag, which is committed only when the last stack write is accepted.
// Ports:
//   clk, reset (async, active high)
//   in_valid/in_ready, in_kind, in_result, in_result_hi, in_carry, in_carry_we
//   flush        - drop the pending result, no carry update
//   stack_valid/stack_ready, stack_op, stack_data
//   carry        - architectural carry flag
//   busy         - sequencer not idle
// Build option: ALU_OVERFLOW_FLAG_EN adds in_overflow / overflow, committed
//   with the same timing and write enable as carry.
module alu_result_commit
  import core0_pkg::*;
#(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_kind,
  input  logic [WORD_WIDTH-1:0] in_result,
  input  logic [WORD_WIDTH-1:0] in_result_hi,
  input  logic                  in_carry,
  input  logic                  in_carry_we,
`ifdef ALU_OVERFLOW_FLAG_EN
  input  logic                  in_overflow,
  output logic                  overflow,
`endif
  input  logic                  flush,
  output logic                  stack_valid,
  input  logic                  stack_ready,
  output logic [1:0]            stack_op,
  output logic [WORD_WIDTH-1:0] stack_data,
  output logic                  carry,
  output logic                  busy
);

  commit_state_t         state;
  commit_kind_t          kind_q;
  stack_op_t             op_q;
  logic [WORD_WIDTH-1:0] hi_q;
  logic                  carry_q;
  logic                  carry_we_q;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic                  ovf_q;
`endif
  logic                  last_wr;
  logic                  accept;

  // The write now on the port is the final one for this result.
  assign last_wr  = (state == ST_WR_HI) ||
                    ((state == ST_WR_LO) && (kind_q != KIND_DOUBLE));
  // Taking a new result while the final write retires avoids an idle bubble.
  assign in_ready = !reset && !flush &&
                    ((state == ST_IDLE) || (last_wr && stack_ready));
  assign accept   = in_valid && in_ready;
  assign busy     = (state != ST_IDLE);
  assign stack_op = op_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      kind_q      <= KIND_REPLACE;
      op_q        <= OP_REPLACE_TOP;
      hi_q        <= '0;
      carry_q     <= 1'b0;
      carry_we_q  <= 1'b0;
      stack_valid <= 1'b0;
      stack_data  <= '0;
      carry       <= 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
      ovf_q       <= 1'b0;
      overflow    <= 1'b0;
`endif
    end else if (flush) begin
      // Pending result is discarded; flags keep their old value.
      state       <= ST_IDLE;
      stack_valid <= 1'b0;
    end else begin
      if (stack_valid && stack_ready) begin
        if ((state == ST_WR_LO) && (kind_q == KIND_DOUBLE)) begin
          state      <= ST_WR_HI;
          op_q       <= OP_PUSH;
          stack_data <= hi_q;
        end else begin
          // Commit uses the retiring result's latched flags (pre-accept values).
          if (carry_we_q) begin
            carry    <= carry_q;
`ifdef ALU_OVERFLOW_FLAG_EN
            overflow <= ovf_q;
`endif
          end
          state       <= ST_IDLE;
          stack_valid <= 1'b0;
        end
      end
      // A same-cycle accept overrides the return to IDLE above.
      if (accept) begin
        state       <= ST_WR_LO;
        kind_q      <= commit_kind_t'(in_kind);
        op_q        <= kind_to_op(commit_kind_t'(in_kind));
        hi_q        <= in_result_hi;
        carry_q     <= in_carry;
        carry_we_q  <= in_carry_we;
        stack_valid <= 1'b1;
        stack_data  <= in_result;
`ifdef ALU_OVERFLOW_FLAG_EN
        ovf_q       <= in_overflow;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_result_commit.sv
// tb_alu_result_commit: directed bench for alu_result_commit (WORD_WIDTH=32).
// Define ALU_OVERFLOW_FLAG_EN to also exercise the overflow flag.
module tb_alu_result_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_kind;
  logic [31:0] in_result;
  logic [31:0] in_result_hi;
  logic        in_carry;
  logic        in_carry_we;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic        in_overflow;
  logic        overflow;
`endif
  logic        flush;
  logic        stack_valid;
  logic        stack_ready;
  logic [1:0]  stack_op;
  logic [31:0] stack_data;
  logic        carry;
  logic        busy;

  int total = 0;
  int fails = 0;

  alu_result_commit #(.WORD_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_result(in_result), .in_result_hi(in_result_hi),
    .in_carry(in_carry), .in_carry_we(in_carry_we),
`ifdef ALU_OVERFLOW_FLAG_EN
    .in_overflow(in_overflow), .overflow(overflow),
`endif
    .flush(flush),
    .stack_valid(stack_valid), .stack_ready(stack_ready),
    .stack_op(stack_op), .stack_data(stack_data),
    .carry(carry), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [1:0] k, input logic [31:0] lo, input logic [31:0] hi,
                       input logic c, input logic we);
    in_valid     = 1'b1;
    in_kind      = k;
    in_result    = lo;
    in_result_hi = hi;
    in_carry     = c;
    in_carry_we  = we;
  endtask

  initial begin
    #20000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_kind = 2'd0; in_result = '0; in_result_hi = '0;
    in_carry = 1'b0; in_carry_we = 1'b0; flush = 1'b0; stack_ready = 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
    in_overflow = 1'b0;
`endif
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_stack_valid", {31'd0, stack_valid}, 32'd0);
    chk("rst_stack_op", {30'd0, stack_op}, 32'd0);
    chk("rst_stack_data", stack_data, 32'd0);
    chk("rst_carry", {31'd0, carry}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    step(); step();
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // POP_REPLACE 5 with carry write
    drive(2'd1, 32'h5, 32'h0, 1'b1, 1'b1);
`ifdef ALU_OVERFLOW_FLAG_EN
    in_overflow = 1'b1;
`endif
    stack_ready = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef ALU_OVERFLOW_FLAG_EN
    in_overflow = 1'b0;
`endif
    chk("pop_valid", {31'd0, stack_valid}, 32'd1);
    chk("pop_op", {30'd0, stack_op}, 32'd1);
    chk("pop_data", stack_data, 32'h5);
    chk("pop_carry_before", {31'd0, carry}, 32'd0);
    step();
    chk("pop_carry_after", {31'd0, carry}, 32'd1);
    chk("pop_valid_drop", {31'd0, stack_valid}, 32'd0);
    chk("pop_busy_drop", {31'd0, busy}, 32'd0);
`ifdef ALU_OVERFLOW_FLAG_EN
    chk("pop_overflow", {31'd0, overflow}, 32'd1);
`endif

    // Reset while WR_LO stalled
    drive(2'd0, 32'h77, 32'h0, 1'b1, 1'b1);
    stack_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("rst2_valid_pre", {31'd0, stack_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst2_valid", {31'd0, stack_valid}, 32'd0);
    chk("rst2_carry", {31'd0, carry}, 32'd0);
    chk("rst2_busy", {31'd0, busy}, 32'd0);
`ifdef ALU_OVERFLOW_FLAG_EN
    chk("rst2_overflow", {31'd0, overflow}, 32'd0);
`endif
    #3 reset = 1'b0;
    step();

    // DOUBLE with 3 stall cycles on the low word
    drive(2'd3, 32'hDEADBEEF, 32'h1, 1'b1, 1'b1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("dbl_lo_valid", {31'd0, stack_valid}, 32'd1);
      chk("dbl_lo_data", stack_data, 32'hDEADBEEF);
      chk("dbl_lo_op", {30'd0, stack_op}, 32'd1);
      chk("dbl_lo_carry", {31'd0, carry}, 32'd0);
      step();
    end
    stack_ready = 1'b1;
    #1;
    chk("dbl_lo_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("dbl_hi_valid", {31'd0, stack_valid}, 32'd1);
    chk("dbl_hi_data", stack_data, 32'h1);
    chk("dbl_hi_op", {30'd0, stack_op}, 32'd2);
    chk("dbl_hi_carry", {31'd0, carry}, 32'd0);
    chk("dbl_hi_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("dbl_done_valid", {31'd0, stack_valid}, 32'd0);
    chk("dbl_done_carry", {31'd0, carry}, 32'd1);

    // Four back-to-back PUSHes, no carry write
    drive(2'd2, 32'd1, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("push_valid", {31'd0, stack_valid}, 32'd1);
      chk("push_data", stack_data, k);
      chk("push_op", {30'd0, stack_op}, 32'd2);
      in_result = k + 1;
      if (k == 4) in_valid = 1'b0;
    end
    step();
    chk("push_done_valid", {31'd0, stack_valid}, 32'd0);
    chk("push_carry_kept", {31'd0, carry}, 32'd1);

    // Clear carry with a REPLACE
    drive(2'd0, 32'h9, 32'h0, 1'b0, 1'b1);
    step();
    in_valid = 1'b0;
    chk("clr_op", {30'd0, stack_op}, 32'd0);
    step();
    chk("clr_carry", {31'd0, carry}, 32'd0);

    // Flush while WR_LO stalled
    drive(2'd0, 32'hAA, 32'h0, 1'b1, 1'b1);
    stack_ready = 1'b0;
    step();
    chk("fl_valid_pre", {31'd0, stack_valid}, 32'd1);
    flush = 1'b1;          // in_valid still high: accept must be suppressed
    #1;
    chk("fl_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    stack_ready = 1'b1;
    chk("fl_valid", {31'd0, stack_valid}, 32'd0);
    chk("fl_busy", {31'd0, busy}, 32'd0);
    chk("fl_carry", {31'd0, carry}, 32'd0);
    step();
    chk("fl_valid2", {31'd0, stack_valid}, 32'd0);
    chk("fl_carry2", {31'd0, carry}, 32'd0);

`ifdef ALU_OVERFLOW_FLAG_EN
    // Overflow set, then cleared, alongside carry
    drive(2'd2, 32'h3, 32'h0, 1'b1, 1'b1);
    in_overflow = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ovf_before", {31'd0, overflow}, 32'd0);
    step();
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_carry", {31'd0, carry}, 32'd1);
    drive(2'd2, 32'h4, 32'h0, 1'b0, 1'b0);
    in_overflow = 1'b0;
    step();
    in_valid = 1'b0;
    step();
    chk("ovf_no_we", {31'd0, overflow}, 32'd1);
`endif

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
